// File: rtl/JZJCoreFTypes.sv
// ============================================================================
//  Module      : JZJCoreFTypes
//  Description : Shared types and funct3 constants for the MMIO load/store unit
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package JZJCoreFTypes;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } LsuOp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } LsuState_t;

    localparam logic [2:0] c_funct3Byte      = 3'b000;
    localparam logic [2:0] c_funct3Half      = 3'b001;
    localparam logic [2:0] c_funct3Word      = 3'b010;
    localparam logic [2:0] c_funct3ByteUnsig = 3'b100;
    localparam logic [2:0] c_funct3HalfUnsig = 3'b101;

    function automatic logic isBadFunct3(input LsuOp_t op, input logic [2:0] funct3);
        if (op == LOAD)
            return !(funct3 inside {c_funct3Byte, c_funct3Half, c_funct3Word,
                                    c_funct3ByteUnsig, c_funct3HalfUnsig});
        else
            return !(funct3 inside {c_funct3Byte, c_funct3Half, c_funct3Word});
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_lsu_ram.sv
// ============================================================================
//  Module      : mmio_lsu_ram
//  Description : True-dual-port RAM, read-first port A (R/W), read-only port B
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mmio_lsu_ram #(
    parameter int    A_WIDTH   = 12,
    parameter string INIT_FILE = ""
) (
    input  logic               i_clock,
    input  logic               i_writeEnable,
    input  logic [A_WIDTH-1:0] i_addrA,
    input  logic [31:0]        i_wdataA,
    output logic [31:0]        o_rdataA,
    input  logic [A_WIDTH-1:0] i_addrB,
    output logic [31:0]        o_rdataB
);

    logic [31:0] r_mem [2**A_WIDTH];
    logic [31:0] r_rdataA;
    logic [31:0] r_rdataB;

    // Both ports read-first: a same-edge write is only visible on the next read
    always_ff @(posedge i_clock) begin
        if (i_writeEnable) r_mem[i_addrA] <= i_wdataA;
        r_rdataA <= r_mem[i_addrA];
    end

    always_ff @(posedge i_clock) begin
        r_rdataB <= r_mem[i_addrB];
    end

    assign o_rdataA = r_rdataA;
    assign o_rdataB = r_rdataB;

endmodule

`default_nettype wire

// File: rtl/mmio_load_store_unit.sv
// ============================================================================
//  Module      : mmio_load_store_unit
//  Description : RV32I load/store unit over RAM plus memory-mapped I/O ports
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mmio_load_store_unit
    import JZJCoreFTypes::*;
#(
    parameter int    RAM_A_WIDTH          = 12,
    parameter int    NUM_PORTS            = 8,
    parameter string INITIAL_MEM_CONTENTS = "initialRam.mem"
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  LsuOp_t                      req_op,
    input  logic [2:0]                  req_funct3,
    input  logic [31:0]                 req_address,
    input  logic [31:0]                 req_wdata,
    output logic                        resp_valid,
    output logic [31:0]                 resp_rdata,
    output logic                        resp_unaligned,
    output logic                        resp_bad_funct3,
    input  logic [31:0]                 instruction_address,
    output logic [31:0]                 instruction,
    input  logic [NUM_PORTS-1:0][31:0]  port_in,
    output logic [NUM_PORTS-1:0][31:0]  port_out
);

    localparam logic [29:0] c_portBaseWord  = 30'(2**30 - NUM_PORTS);
    localparam logic [3:0]  c_portIndexBias = 4'(16 - NUM_PORTS);

    LsuState_t                 r_state, w_nextState;
    LsuOp_t                    r_op;
    logic [2:0]                r_funct3;
    logic [31:0]               r_addr, r_wdata, r_portSample;
    logic                      r_unaligned, r_badFunct3;
    logic [NUM_PORTS-1:0][31:0] r_portOut;

    logic        w_reqBad, w_reqUnaligned, w_accept, w_isPort, w_writeCycle;
    logic [3:0]  w_portIndex;
    logic [1:0]  w_offset;
    logic [31:0] w_ramRdata, w_portInWord, w_portOutWord, w_srcWord, w_shifted;
    logic [31:0] w_loadData, w_mask, w_storeData, w_mergedWord;
    logic        w_unusedFetchBits;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_reqBad     = isBadFunct3(req_op, req_funct3);
    // A bad funct3 has no defined access size, so it is never also flagged unaligned
    assign w_reqUnaligned = !w_reqBad &&
        (((req_funct3[1:0] == 2'b01) && req_address[0]) ||
         ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00)));

    assign w_isPort     = (r_addr[31:2] >= c_portBaseWord);
    assign w_portIndex  = r_addr[5:2] - c_portIndexBias;
    assign w_offset     = r_addr[1:0];
    assign w_writeCycle = (r_state == WRITE);

    always_comb begin
        w_portInWord  = '0;
        w_portOutWord = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_portIndex == 4'(i)) begin
                w_portInWord  = port_in[i];
                w_portOutWord = r_portOut[i];
            end
        end
    end

    always_comb begin
        w_srcWord = w_isPort ? r_portSample : w_ramRdata;
        w_shifted = w_srcWord >> {w_offset, 3'b000};
        unique case (r_funct3[1:0])
            2'b00:   w_loadData = {{24{~r_funct3[2] & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_loadData = {{16{~r_funct3[2] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // Sub-word data is replicated across lanes; the mask picks the addressed lanes
    always_comb begin
        unique case (r_funct3[1:0])
            2'b00: begin
                w_mask      = 32'h0000_00FF << {w_offset, 3'b000};
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_mask      = 32'h0000_FFFF << {w_offset, 3'b000};
                w_storeData = {2{r_wdata[15:0]}};
            end
            default: begin
                w_mask      = 32'hFFFF_FFFF;
                w_storeData = r_wdata;
            end
        endcase
        w_mergedWord = ((w_isPort ? w_portOutWord : w_ramRdata) & ~w_mask) |
                       (w_storeData & w_mask);
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_reqBad || w_reqUnaligned)
                        w_nextState = RESP;
                    else if ((req_op == STORE) && (req_funct3 == c_funct3Word))
                        w_nextState = WRITE;
                    else
                        w_nextState = READ;
                end
            end
            READ:    w_nextState = (r_op == LOAD) ? RESP : WRITE;
            WRITE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op         <= LOAD;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_unaligned  <= 1'b0;
            r_badFunct3  <= 1'b0;
            r_portSample <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= req_op;
                r_funct3    <= req_funct3;
                r_addr      <= req_address;
                r_wdata     <= req_wdata;
                r_unaligned <= w_reqUnaligned;
                r_badFunct3 <= w_reqBad;
            end
            if (r_state == READ) r_portSample <= w_portInWord;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_portOut <= '0;
        end else if (w_writeCycle && w_isPort) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_portIndex == 4'(i)) r_portOut[i] <= w_mergedWord;
            end
        end
    end

    mmio_lsu_ram #(
        .A_WIDTH   (RAM_A_WIDTH),
        .INIT_FILE (INITIAL_MEM_CONTENTS)
    ) u_ram (
        .i_clock       (clock),
        .i_writeEnable (w_writeCycle && !w_isPort),
        .i_addrA       (r_addr[RAM_A_WIDTH+1:2]),
        .i_wdataA      (w_mergedWord),
        .o_rdataA      (w_ramRdata),
        .i_addrB       (instruction_address[RAM_A_WIDTH+1:2]),
        .o_rdataB      (instruction)
    );

    assign w_unusedFetchBits = ^{instruction_address[31:RAM_A_WIDTH+2], instruction_address[1:0]};

    assign req_ready       = (r_state == IDLE);
    assign resp_valid      = (r_state == RESP);
    assign resp_unaligned  = resp_valid && r_unaligned;
    assign resp_bad_funct3 = resp_valid && r_badFunct3;
    assign resp_rdata      = (resp_valid && (r_op == LOAD) && !r_unaligned && !r_badFunct3)
                             ? w_loadData : 32'h0;
    assign port_out        = r_portOut;

endmodule

`default_nettype wire

// File: tb/tb_mmio_load_store_unit.sv
// ============================================================================
//  Module      : tb_mmio_load_store_unit
//  Description : Randomised and directed bench for mmio_load_store_unit
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_load_store_unit;
    import JZJCoreFTypes::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset, reqValid, reqValidW;
    LsuOp_t           reqOp;
    logic [2:0]       reqF3;
    logic [31:0]      reqAddr, reqWdata, instrAddr;
    logic [7:0][31:0] portIn;

    logic             ready, respValid, unal, bad;
    logic [31:0]      rdata, instr;
    logic [7:0][31:0] portOut;
    logic             readyW, respValidW, unalW, badW;
    logic [31:0]      rdataW, instrW;
    logic [7:0][31:0] portOutW;

    int checks = 0;
    int fails  = 0;

    // Reference model: byte-addressed RAM image and port output registers
    logic [7:0]  ramB [int];
    logic [31:0] pOut [8];

    mmio_load_store_unit #(.RAM_A_WIDTH(12), .NUM_PORTS(8), .INITIAL_MEM_CONTENTS("")) dut (
        .clock(clock), .reset(reset), .req_valid(reqValid), .req_ready(ready),
        .req_op(reqOp), .req_funct3(reqF3), .req_address(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid), .resp_rdata(rdata), .resp_unaligned(unal),
        .resp_bad_funct3(bad), .instruction_address(instrAddr), .instruction(instr),
        .port_in(portIn), .port_out(portOut));

    mmio_load_store_unit #(.RAM_A_WIDTH(4), .NUM_PORTS(8), .INITIAL_MEM_CONTENTS("")) dutW (
        .clock(clock), .reset(reset), .req_valid(reqValidW), .req_ready(readyW),
        .req_op(reqOp), .req_funct3(reqF3), .req_address(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValidW), .resp_rdata(rdataW), .resp_unaligned(unalW),
        .resp_bad_funct3(badW), .instruction_address(instrAddr), .instruction(instrW),
        .port_in(portIn), .port_out(portOutW));

    function automatic int keyOf(input logic [31:0] a, input int k);
        return int'(a[13:2]) * 4 + k;
    endfunction

    // Spec-level expectation for one request; also commits stores into the model
    task automatic modelRequest(input LsuOp_t op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] eRd,
                                output logic eUn, output logic eBad, output int eLat);
        int size, off, idx;
        bit isPort;
        logic [31:0] v;
        size = 1 << f3[1:0];
        off  = int'(addr % 4);
        eBad = (op == LOAD) ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
        eUn  = !eBad && ((size == 2 && off % 2 == 1) || (size == 4 && off != 0));
        eRd  = 0;
        isPort = ({32'd0, addr} >= 64'h1_0000_0000 - 64'd32);
        idx    = int'((addr - 32'hFFFF_FFE0) / 4);
        if (eBad || eUn) begin
            eLat = 1;
        end else if (op == LOAD) begin
            eLat = 2;
            v = 0;
            for (int k = 0; k < size; k++)
                v = v | (32'(isPort ? portIn[idx][8*(off+k) +: 8] : ramB[keyOf(addr, off + k)]) << (8*k));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 1);
            eRd = v;
        end else begin
            eLat = (size == 4) ? 2 : 3;
            for (int k = 0; k < size; k++) begin
                if (isPort) pOut[idx][8*(off+k) +: 8] = wd[8*k +: 8];
                else        ramB[keyOf(addr, off + k)] = wd[8*k +: 8];
            end
        end
    endtask

    // Issues one request on the chosen instance; scrambles inputs right after acceptance
    task automatic doReq(input bit sel, input LsuOp_t op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic un, output logic bd,
                         output int lat);
        @(negedge clock);
        reqOp = op; reqF3 = f3; reqAddr = addr; reqWdata = wd;
        if (sel) reqValidW = 1'b1; else reqValid = 1'b1;
        checks++;
        if ((sel ? readyW : ready) !== 1'b1) begin
            fails++; $display("FAIL req_ready_idle: got %b want 1", sel ? readyW : ready);
        end
        @(posedge clock); #1;
        reqValid = 1'b0; reqValidW = 1'b0;
        reqOp = LsuOp_t'($urandom_range(0, 1)); reqF3 = 3'($urandom);
        reqAddr = $urandom; reqWdata = $urandom;
        lat = 0; rd = 'x; un = 1'bx; bd = 1'bx;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if ((sel ? respValidW : respValid) === 1'b1) begin
                lat = c;
                rd  = sel ? rdataW : rdata;
                un  = sel ? unalW : unal;
                bd  = sel ? badW : bad;
            end else begin
                @(posedge clock); #1;
            end
        end
        checks++;
        if (lat == 0) begin fails++; $display("FAIL resp_timeout: no resp_valid within 8 cycles of accept"); end
        @(posedge clock); #1;
        checks++;
        if ((sel ? respValidW : respValid) !== 1'b0) begin
            fails++; $display("FAIL resp_one_cycle: resp_valid got 1 want 0");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; reqValid = 0; reqValidW = 0; reqOp = LOAD; reqF3 = 0;
        reqAddr = 0; reqWdata = 0; instrAddr = 0; portIn = '0;
        #12;
        checks += 6;
        if (ready !== 1'b1)   begin fails++; $display("FAIL rst_ready: got %b want 1", ready); end
        if (respValid !== 0)  begin fails++; $display("FAIL rst_resp_valid: got %b want 0", respValid); end
        if (rdata !== 0)      begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        if (unal !== 0)       begin fails++; $display("FAIL rst_unaligned: got %b want 0", unal); end
        if (bad !== 0)        begin fails++; $display("FAIL rst_bad_funct3: got %b want 0", bad); end
        if (portOut !== '0)   begin fails++; $display("FAIL rst_port_out: got %h want 0", portOut); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic un, bd; int lat;
        doReq(0, STORE, 3'b010, 32'h10, 32'h1122_3344, rd, un, bd, lat);
        checks += 2;
        if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d want 2", lat); end
        if (rd !== 0)  begin fails++; $display("FAIL sw_rdata: got %h want 0", rd); end
        doReq(0, LOAD, 3'b010, 32'h10, 32'h0, rd, un, bd, lat);
        checks += 3;
        if (rd !== 32'h1122_3344) begin fails++; $display("FAIL lw_data: got %h want 11223344", rd); end
        if (lat !== 2) begin fails++; $display("FAIL lw_latency: got %0d want 2", lat); end
        if ({un, bd} !== 2'b00) begin fails++; $display("FAIL lw_flags: got %b want 00", {un, bd}); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic un, bd; int lat;
        doReq(0, STORE, 3'b000, 32'h13, 32'h5A5A_5AAB, rd, un, bd, lat);
        checks++;
        if (lat !== 3) begin fails++; $display("FAIL sb_latency: got %0d want 3", lat); end
        doReq(0, LOAD, 3'b010, 32'h10, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'hAB22_3344) begin fails++; $display("FAIL sb_merge: got %h want ab223344", rd); end
        doReq(0, LOAD, 3'b000, 32'h13, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'hFFFF_FFAB) begin fails++; $display("FAIL lb_sext: got %h want ffffffab", rd); end
        doReq(0, LOAD, 3'b100, 32'h13, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h0000_00AB) begin fails++; $display("FAIL lbu_zext: got %h want 000000ab", rd); end
        doReq(0, LOAD, 3'b001, 32'h12, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'hFFFF_AB22) begin fails++; $display("FAIL lh_sext: got %h want ffffab22", rd); end
        doReq(0, LOAD, 3'b101, 32'h12, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h0000_AB22) begin fails++; $display("FAIL lhu_zext: got %h want 0000ab22", rd); end
    endtask

    task automatic test_ports();
        logic [31:0] rd; logic un, bd; int lat;
        doReq(0, STORE, 3'b001, 32'hFFFF_FFE2, 32'h1234_BEEF, rd, un, bd, lat);
        checks += 3;
        if (portOut[0] !== 32'hBEEF_0000) begin fails++; $display("FAIL port_sh: got %h want beef0000", portOut[0]); end
        if (portOut[7:1] !== '0) begin fails++; $display("FAIL port_others: got %h want 0", portOut[7:1]); end
        if (lat !== 3) begin fails++; $display("FAIL port_sh_latency: got %0d want 3", lat); end
        for (int i = 0; i < 8; i++) portIn[i] = $urandom;
        portIn[7] = 32'h1234_5678;
        doReq(0, LOAD, 3'b010, 32'hFFFF_FFFC, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h1234_5678) begin fails++; $display("FAIL port_lw: got %h want 12345678", rd); end
        doReq(0, LOAD, 3'b100, 32'hFFFF_FFFD, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h0000_0056) begin fails++; $display("FAIL port_lbu: got %h want 00000056", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic un, bd; int lat;
        doReq(0, STORE, 3'b010, 32'h20, 32'h5566_7788, rd, un, bd, lat);
        doReq(0, LOAD, 3'b010, 32'h21, 0, rd, un, bd, lat);
        checks += 3;
        if ({un, bd} !== 2'b10) begin fails++; $display("FAIL lw_unaligned_flags: got %b want 10", {un, bd}); end
        if (lat !== 1) begin fails++; $display("FAIL err_latency: got %0d want 1", lat); end
        if (rd !== 0)  begin fails++; $display("FAIL err_rdata: got %h want 0", rd); end
        doReq(0, STORE, 3'b011, 32'h20, 32'hDEAD_BEEF, rd, un, bd, lat);
        checks++;
        if ({un, bd} !== 2'b01) begin fails++; $display("FAIL st_bad_funct3: got %b want 01", {un, bd}); end
        doReq(0, STORE, 3'b001, 32'h23, 32'hDEAD_BEEF, rd, un, bd, lat);
        checks++;
        if ({un, bd} !== 2'b10) begin fails++; $display("FAIL sh_unaligned: got %b want 10", {un, bd}); end
        doReq(0, STORE, 3'b100, 32'hFFFF_FFE4, 32'hFFFF_FFFF, rd, un, bd, lat);
        checks++;
        if (portOut[1] !== 0) begin fails++; $display("FAIL err_port_write: got %h want 0", portOut[1]); end
        doReq(0, LOAD, 3'b010, 32'h20, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h5566_7788) begin fails++; $display("FAIL err_ram_write: got %h want 55667788", rd); end
    endtask

    task automatic test_fetch();
        @(negedge clock); instrAddr = 32'h10;
        @(posedge clock); #1;
        checks++;
        if (instr !== 32'hAB22_3344) begin fails++; $display("FAIL fetch: got %h want ab223344", instr); end
        @(negedge clock);
        instrAddr = 32'h20;
        reqOp = STORE; reqF3 = 3'b010; reqAddr = 32'h20; reqWdata = 32'h0BAD_F00D; reqValid = 1'b1;
        @(posedge clock); #1; reqValid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (instr !== 32'h5566_7788) begin fails++; $display("FAIL fetch_collision_old: got %h want 55667788", instr); end
        @(posedge clock); #1;
        checks++;
        if (instr !== 32'h0BAD_F00D) begin fails++; $display("FAIL fetch_after_write: got %h want 0badf00d", instr); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic un, bd; int lat;
        @(negedge clock);
        reqOp = STORE; reqF3 = 3'b000; reqAddr = 32'h21; reqWdata = 32'h77; reqValid = 1'b1;
        @(posedge clock); #1; reqValid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; #1;
        checks += 3;
        if (ready !== 1'b1)  begin fails++; $display("FAIL midrst_ready: got %b want 1", ready); end
        if (respValid !== 0) begin fails++; $display("FAIL midrst_resp_valid: got %b want 0", respValid); end
        if (portOut !== '0)  begin fails++; $display("FAIL midrst_port_out: got %h want 0", portOut); end
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        doReq(0, LOAD, 3'b010, 32'h20, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL midrst_ram: got %h want 0badf00d", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic un, bd; int lat;
        doReq(1, STORE, 3'b010, 32'h40, 32'hCAFE_F00D, rd, un, bd, lat);
        doReq(1, LOAD, 3'b010, 32'h00, 0, rd, un, bd, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL wrap: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, eRd, a, wd, eWord; logic un, bd, eUn, eBad; int lat, eLat;
        LsuOp_t op; logic [2:0] f3;
        for (int i = 0; i < 8; i++) pOut[i] = 0;
        for (int w = 64; w < 80; w++) begin
            wd = $urandom;
            modelRequest(STORE, 3'b010, 32'(w * 4), wd, eRd, eUn, eBad, eLat);
            doReq(0, STORE, 3'b010, 32'(w * 4), wd, rd, un, bd, lat);
        end
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 8; i++) portIn[i] = $urandom;
            op = LsuOp_t'($urandom_range(0, 1));
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else a = (32'($urandom_range(0, 16'h3FFF)) << 14) | (32'($urandom_range(64, 79)) << 2)
                     | 32'($urandom_range(0, 3));
            wd = $urandom;
            instrAddr = 32'($urandom_range(64, 79)) << 2;
            modelRequest(op, f3, a, wd, eRd, eUn, eBad, eLat);
            doReq(0, op, f3, a, wd, rd, un, bd, lat);
            checks += 6;
            if (rd !== eRd)   begin fails++; $display("FAIL rnd_rdata #%0d op=%0d f3=%0d a=%h: got %h want %h", n, op, f3, a, rd, eRd); end
            if (un !== eUn)   begin fails++; $display("FAIL rnd_unaligned #%0d: got %b want %b", n, un, eUn); end
            if (bd !== eBad)  begin fails++; $display("FAIL rnd_bad_funct3 #%0d: got %b want %b", n, bd, eBad); end
            if (lat !== eLat) begin fails++; $display("FAIL rnd_latency #%0d: got %0d want %0d", n, lat, eLat); end
            begin
                logic [7:0][31:0] ePorts;
                for (int i = 0; i < 8; i++) ePorts[i] = pOut[i];
                if (portOut !== ePorts) begin fails++; $display("FAIL rnd_port_out #%0d: got %h want %h", n, portOut, ePorts); end
            end
            eWord = 0;
            for (int k = 0; k < 4; k++) eWord = eWord | (32'(ramB[keyOf(instrAddr, k)]) << (8*k));
            if (instr !== eWord) begin fails++; $display("FAIL rnd_fetch #%0d: got %h want %h", n, instr, eWord); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_ports();
        test_errors();
        test_fetch();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
